// File: rtl/alu_pipe.sv
// Handshaked registered ALU with an iterative unsigned multiply. Latency: 1 cycle for single-cycle ops, WIDTH cycles for mul.
// Backpressure: in_ready drops while a mul runs or a held result is not being taken by out_ready.
module alu_pipe #(
    parameter int WIDTH = 64,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               pend_ne;
    logic               pend_lt;

    logic out_free;
    logic accept;
    logic is_mul_op;
    logic mul_last;
    logic mul_done;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ne;
    logic             alu_lt;

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == S_IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign is_mul_op = (ctrl_ALUopcode == OP_MUL);
    // The last iteration is folded into the output load so mul takes exactly WIDTH cycles.
    assign mul_last  = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));
    assign mul_done  = mul_last && out_free;
    assign prod      = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        sum     = data_operandA + data_operandB;
        diff    = data_operandA - data_operandB;
        add_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                  (sum[WIDTH-1] != data_operandA[WIDTH-1]);
        sub_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                  (diff[WIDTH-1] != data_operandA[WIDTH-1]);
        alu_ne  = (data_operandA != data_operandB);
        alu_lt  = diff[WIDTH-1] ^ sub_ovf;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
            OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
            OP_AND: alu_res = data_operandA & data_operandB;
            OP_OR:  alu_res = data_operandA | data_operandB;
            OP_SLL: alu_res = data_operandA << ctrl_shiftamt;
            OP_SRA: alu_res = $signed(data_operandA) >>> ctrl_shiftamt;
            default: begin alu_res = '0; alu_ovf = 1'b0; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_mul_op) state_nxt = S_MUL;
            S_MUL:   if (mul_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            cnt         <= '0;
            pend_ne     <= 1'b0;
            pend_lt     <= 1'b0;
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept && is_mul_op) begin
                mcand   <= {{WIDTH{1'b0}}, data_operandA};
                mplier  <= data_operandB;
                acc     <= '0;
                cnt     <= '0;
                pend_ne <= alu_ne;
                pend_lt <= alu_lt;
            end else if ((state == S_MUL) && !mul_last) begin
                acc    <= prod;
                mplier <= mplier >> 1;
                mcand  <= mcand << 1;
                cnt    <= cnt + SHW'(1);
            end

            if (accept && !is_mul_op) begin
                data_result <= alu_res;
                overflow    <= alu_ovf;
                isNotEqual  <= alu_ne;
                isLessThan  <= alu_lt;
                out_valid   <= 1'b1;
            end else if (mul_done) begin
                data_result <= prod[WIDTH-1:0];
                overflow    <= |prod[2*WIDTH-1:WIDTH];
                isNotEqual  <= pend_ne;
                isLessThan  <= pend_lt;
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ne;
        logic         lt;
        logic         ovf;
    } exp_t;

    localparam logic signed [64:0] SMAX = 65'sd9223372036854775807;
    localparam logic signed [64:0] SMIN = -65'sd9223372036854775808;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [4:0]   ctrl_ALUopcode;
    logic [5:0]   ctrl_shiftamt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_result;
    logic         isNotEqual;
    logic         isLessThan;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_pipe #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .isNotEqual(isNotEqual),
        .isLessThan(isLessThan), .overflow(overflow)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [4:0] op, input logic [5:0] sh);
        exp_t e;
        logic signed [64:0] s;
        logic [127:0] p;
        e.ne  = (a != b);
        e.lt  = ($signed(a) < $signed(b));
        e.res = '0;
        e.ovf = 1'b0;
        case (op)
            5'd0: begin
                s = $signed({a[W-1], a}) + $signed({b[W-1], b});
                e.res = s[W-1:0];
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            5'd1: begin
                s = $signed({a[W-1], a}) - $signed({b[W-1], b});
                e.res = s[W-1:0];
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            5'd2: e.res = a & b;
            5'd3: e.res = a | b;
            5'd4: e.res = a << sh;
            5'd5: e.res = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : '0);
            5'd6: begin
                p = {64'd0, a} * {64'd0, b};
                e.res = p[W-1:0];
                e.ovf = (p[127:64] != 0);
            end
            default: begin e.res = '0; e.ovf = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.res = data_result;
        o.ne  = isNotEqual;
        o.lt  = isLessThan;
        o.ovf = overflow;
        return o;
    endfunction

    // Drives one operation from a negedge until accepted; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op,
                        input logic [5:0] sh, output bit ok);
        ok = 1'b0;
        data_operandA = a; data_operandB = b; ctrl_ALUopcode = op; ctrl_shiftamt = sh;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        if (ok) begin
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data_operandA = '0; data_operandB = '0; ctrl_ALUopcode = '0; ctrl_shiftamt = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || observed() !== exp_t'(0) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b outs=%h in_ready=%b, required 0 / 0 / 1",
                     out_valid, observed(), in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic [4:0]   top [6];
        logic [5:0]   tsh [6];
        exp_t         te [6];
        bit ok;
        ta[0] = 64'h7FFF_FFFF_FFFF_FFFF; tb[0] = 64'd1; top[0] = 5'd0; tsh[0] = 6'd0;
        te[0] = {64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFB; tb[1] = 64'd3; top[1] = 5'd1; tsh[1] = 6'd0;
        te[1] = {64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 1'b0};
        ta[2] = 64'h1234; tb[2] = 64'h1234; top[2] = 5'd1; tsh[2] = 6'd0;
        te[2] = {64'd0, 1'b0, 1'b0, 1'b0};
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'd0; top[3] = 5'd5; tsh[3] = 6'd63;
        te[3] = {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        ta[4] = 64'd1; tb[4] = 64'd0; top[4] = 5'd4; tsh[4] = 6'd63;
        te[4] = {64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0};
        ta[5] = 64'd5; tb[5] = 64'd5; top[5] = 5'd9; tsh[5] = 6'd3;
        te[5] = {64'd0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(ta[i], tb[i], top[i], tsh[i], ok);
            checks++;
            if (!ok || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL directed_%0d_valid: accepted=%b out_valid=%b, required 1 / 1", i, ok, out_valid);
            end
            checks++;
            if (observed() !== te[i]) begin
                failures++;
                $display("FAIL directed_%0d_data: got %h, required %h", i, observed(), te[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] ma [2];
        logic [W-1:0] mb [2];
        exp_t         me [2];
        bit ok;
        int n, busy_ready;
        ma[0] = 64'hFFFF_FFFF_FFFF_FFFF; mb[0] = 64'd2;
        me[0] = {64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b1};
        ma[1] = 64'd3; mb[1] = 64'd7;
        me[1] = {64'd21, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(ma[i], mb[i], 5'd6, 6'd0, ok);
            n = 0; busy_ready = 0;
            while (ok && !out_valid && n < 300) begin
                if (in_ready) busy_ready++;
                @(negedge clock);
                n++;
            end
            checks++;
            if (!ok || n != W) begin
                failures++;
                $display("FAIL mul_%0d_latency: %0d cycles (accepted=%b), required %0d", i, n, ok, W);
            end
            checks++;
            if (busy_ready != 0) begin
                failures++;
                $display("FAIL mul_%0d_in_ready_busy: high on %0d busy cycles, required 0", i, busy_ready);
            end
            checks++;
            if (observed() !== me[i]) begin
                failures++;
                $display("FAIL mul_%0d_data: got %h, required %h", i, observed(), me[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        bit ok;
        logic [W-1:0] a, b;
        exp_t bq [10];
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        e1 = model(a, b, 5'd0, 6'd0);
        send(a, b, 5'd0, 6'd0, ok);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (!ok || in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== e1) begin
                failures++;
                $display("FAIL hold_%0d: in_ready=%b out_valid=%b data=%h, required 0 / 1 / %h",
                         i, in_ready, out_valid, observed(), e1);
            end
            @(negedge clock);
        end
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        e2 = model(a, b, 5'd1, 6'd0);
        data_operandA = a; data_operandB = b; ctrl_ALUopcode = 5'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || observed() !== e2) begin
            failures++;
            $display("FAIL drain_replace: out_valid=%b data=%h, required 1 / %h", out_valid, observed(), e2);
        end
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                data_operandA = a; data_operandB = b; ctrl_ALUopcode = 5'd0; in_valid = 1'b1;
                bq[i] = model(a, b, 5'd0, 6'd0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 10) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_%0d_in_ready: got %b, required 1", i, in_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || observed() !== bq[i-1]) begin
                    failures++;
                    $display("FAIL b2b_%0d_result: out_valid=%b data=%h, required 1 / %h",
                             i - 1, out_valid, observed(), bq[i-1]);
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        logic [W-1:0] a, b;
        logic [4:0] op;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: a = {1'b0, {(W-1){1'b1}}};
                1: b = {1'b1, {(W-1){1'b0}}};
                2: b = a;
                default: ;
            endcase
            op = 5'($urandom_range(0, 7));
            if (op == 5'd6 && $urandom_range(0, 3) != 0) op = 5'd0;
            if (op == 5'd7) op = 5'($urandom_range(7, 31));
            data_operandA = a; data_operandB = b; ctrl_ALUopcode = op;
            ctrl_shiftamt = 6'($urandom_range(0, 63));
            #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0 || observed() !== q[0]) begin
                    failures++;
                    $display("FAIL random_%0d: got %h, required %h (queued %0d)",
                             cyc, observed(), (q.size() != 0) ? q[0] : exp_t'(0), q.size());
                end
                if (out_ready && q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(a, b, op, ctrl_shiftamt));
            @(negedge clock);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (observed() !== q[0]) begin
                    failures++;
                    $display("FAIL random_drain: got %h, required %h", observed(), q[0]);
                end
                void'(q.pop_front());
            end
            @(negedge clock);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL random_outstanding: %0d results never delivered, required 0", q.size());
        end
    endtask

    task automatic test_reset_mid_mul();
        bit ok;
        out_ready = 1'b1;
        @(negedge clock);
        send({$urandom, $urandom}, {$urandom, $urandom}, 5'd6, 6'd0, ok);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (!ok || out_valid !== 1'b0 || observed() !== exp_t'(0) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_mul: accepted=%b out_valid=%b outs=%h in_ready=%b, required 1 / 0 / 0 / 1",
                     ok, out_valid, observed(), in_ready);
        end
        @(negedge clock);
        send(64'd2, 64'd2, 5'd0, 6'd0, ok);
        checks++;
        if (!ok || out_valid !== 1'b1 || data_result !== 64'd4 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_add: out_valid=%b result=%h ovf=%b, required 1 / 4 / 0",
                     out_valid, data_result, overflow);
        end
        repeat (30) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL aborted_mul_output: out_valid=%b, required 0", out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_random();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
